// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared core-wide widths and fetch-buffer sizing.
// The core top overrides FETCH_BUF_DEPTH/FETCH_BUF_SKID here so that
// every instance agrees on them.
package ifu_fetch_buffer_pkg;

    localparam int XLEN            = 32;
    localparam int INSTR_LEN       = 32;

    // Buffer entries; power of two, at least 4.
    localparam int FETCH_BUF_DEPTH = 4;
    // Entries held free for fetches already in flight when stall rises.
    localparam int FETCH_BUF_SKID  = 2;

endpackage : ifu_fetch_buffer_pkg

// File: rtl/ifu_fetch_buffer.sv
// Decoupling FIFO between the IFU output register and decode.
// Circular buffer with first-word-fall-through head, early stall
// generation with skid room, redirect flush and a sticky overflow flag.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics.
// out_valid never depends on out_ready; the head entry and its tag stay
// stable while out_valid=1 and out_ready=0; an entry is consumed exactly
// on a rising edge where out_valid & out_ready & ~flush. The input side has
// no ready: the IFU must honour pipe_stall, and anything arriving while
// full is dropped and recorded in overflow.
module ifu_fetch_buffer
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    parameter int SKID  = FETCH_BUF_SKID
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INSTR_LEN-1:0]         in_instr,
    input  logic                         in_valid,
    input  logic [XLEN-1:0]              in_tag,
    input  logic                         flush,
    output logic                         pipe_stall,
    output logic [INSTR_LEN-1:0]         out_instr,
    output logic [XLEN-1:0]              out_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0]      tag_mem   [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          push;
    logic          pop;

    // A full buffer rejects the push even when the head is popped in the
    // same cycle: fullness is judged on the registered count only.
    always_comb begin
        full      = (count == CW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid & ~flush & ~full;
        pop       = out_valid & out_ready & ~flush;
    end

    // Stall comes from the count flop only, so it has no path from the
    // handshake inputs; it drops during a redirect so the new PC loads.
    always_comb begin
        pipe_stall = ~flush & (count >= CW'(DEPTH - SKID));
    end

    // Head of the buffer falls through combinationally to decode.
    always_comb begin
        out_instr = instr_mem[rd_ptr];
        out_tag   = tag_mem[rd_ptr];
    end

    // Pointer, occupancy and sticky overflow state; flush wins over all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid & full & ~flush) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            tag_mem[wr_ptr]   <= in_tag;
        end
    end

endmodule : ifu_fetch_buffer

// File: tb/tb_ifu_fetch_buffer.sv
// Directed bench for ifu_fetch_buffer at DEPTH=4, SKID=2.
module tb_ifu_fetch_buffer;
    import ifu_fetch_buffer_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [INSTR_LEN-1:0] in_instr;
    logic                 in_valid;
    logic [XLEN-1:0]      in_tag;
    logic                 flush;
    logic                 pipe_stall;
    logic [INSTR_LEN-1:0] out_instr;
    logic [XLEN-1:0]      out_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           count;
    logic                 overflow;

    int n_vec;
    int n_err;

    // Expected contents of the buffer, head first.
    logic [XLEN-1:0] exp_q[$];

    ifu_fetch_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_instr   (in_instr),
        .in_valid   (in_valid),
        .in_tag     (in_tag),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .out_instr  (out_instr),
        .out_tag    (out_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers / drivers ----------------
    function automatic logic [INSTR_LEN-1:0] instr_of(input logic [XLEN-1:0] t);
        return INSTR_LEN'(t) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] t, input logic r, input logic f);
        in_valid  = v;
        in_tag    = t;
        in_instr  = instr_of(t);
        out_ready = r;
        flush     = f;
    endtask

    // Advance one clock; sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push with no pop; records the entry in the expected queue.
    task automatic push_only(input logic [XLEN-1:0] t);
        exp_q.push_back(t);
        drive(1'b1, t, 1'b0, 1'b0);
        tick();
    endtask

    // Check the head against the queue front and retire it from the model.
    task automatic check_and_pop_head(input string tag);
        logic [XLEN-1:0] h;
        h = exp_q.pop_front();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_tag"},   32'(out_tag),   32'(h));
        chk({tag, "_instr"}, 32'(out_instr), 32'(instr_of(h)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [XLEN-1:0] t;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    32'(count),      32'd0);
        chk("rst_valid",    32'(out_valid),  32'd0);
        chk("rst_stall",    32'(pipe_stall), 32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        rst = 1'b0;
        tick();

        // Fill with out_ready low; stall appears at count=2.
        push_only(32'h0);
        chk("fill1_count", 32'(count),      32'd1);
        chk("fill1_valid", 32'(out_valid),  32'd1);
        chk("fill1_tag",   32'(out_tag),    32'h0);
        chk("fill1_stall", 32'(pipe_stall), 32'd0);
        push_only(32'h4);
        chk("fill2_count", 32'(count),      32'd2);
        chk("fill2_stall", 32'(pipe_stall), 32'd1);
        push_only(32'h8);
        chk("fill3_count", 32'(count),      32'd3);
        chk("fill3_tag",   32'(out_tag),    32'h0);
        push_only(32'hC);
        chk("fill4_count", 32'(count),      32'd4);
        chk("fill4_ovf",   32'(overflow),   32'd0);

        // Drain all four in order; pointers wrap back to 0.
        for (int i = 0; i < 4; i++) begin
            check_and_pop_head("drain");
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            chk("drain_count", 32'(count), 32'(3 - i));
        end
        chk("empty_valid", 32'(out_valid),  32'd0);
        chk("empty_stall", 32'(pipe_stall), 32'd0);
        // Pop while empty must be ignored.
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("empty_pop_count", 32'(count), 32'd0);

        // Streaming at count=1 across pointer wrap: no stall, no overflow.
        push_only(32'h10);
        chk("stream_start_count", 32'(count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            t = 32'h14 + 32'(4 * i);
            check_and_pop_head("stream");
            exp_q.push_back(t);
            drive(1'b1, t, 1'b1, 1'b0);
            tick();
            chk("stream_count", 32'(count),      32'd1);
            chk("stream_stall", 32'(pipe_stall), 32'd0);
            chk("stream_ovf",   32'(overflow),   32'd0);
        end

        // Simultaneous push and pop at count=2 leaves count unchanged.
        push_only(32'h64);
        chk("pp_pre_count", 32'(count), 32'd2);
        check_and_pop_head("pp");
        exp_q.push_back(32'h68);
        drive(1'b1, 32'h68, 1'b1, 1'b0);
        tick();
        chk("pp_count", 32'(count),   32'd2);
        chk("pp_head",  32'(out_tag), 32'(exp_q[0]));

        // Flush at count=3 with in_valid and out_ready high.
        push_only(32'h6C);
        chk("preflush_count", 32'(count),      32'd3);
        chk("preflush_stall", 32'(pipe_stall), 32'd1);
        drive(1'b1, 32'h70, 1'b1, 1'b1);
        #1;
        chk("flush_stall_low", 32'(pipe_stall), 32'd0);
        tick();
        exp_q.delete();
        chk("flush_count", 32'(count),      32'd0);
        chk("flush_valid", 32'(out_valid),  32'd0);
        chk("flush_stall", 32'(pipe_stall), 32'd0);
        push_only(32'h100);
        chk("postflush_count", 32'(count),   32'd1);
        chk("postflush_tag",   32'(out_tag), 32'h100);

        // Fill to full, then push+pop while full: head leaves, input dropped.
        push_only(32'h104);
        push_only(32'h108);
        push_only(32'h10C);
        chk("full_count", 32'(count), 32'd4);
        check_and_pop_head("ovf_head");
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        chk("ovf_count", 32'(count),    32'd3);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_head",  32'(out_tag),  32'h104);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("ovf_held_after_flush", 32'(overflow), 32'd1);
        exp_q.delete();
        push_only(32'h300);
        push_only(32'h304);
        push_only(32'h308);
        chk("prereset_count", 32'(count),    32'd3);
        chk("prereset_ovf",   32'(overflow), 32'd1);

        // Asynchronous reset mid-cycle clears state without a clock edge.
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count),      32'd0);
        chk("arst_valid", 32'(out_valid),  32'd0);
        chk("arst_stall", 32'(pipe_stall), 32'd0);
        chk("arst_ovf",   32'(overflow),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ifu_fetch_buffer
